// File: rtl/jtag_tap_core.sv
// jtag_tap_core
//   JTAG test access port: the 16-state TAP controller, an IR_LEN-bit
//   instruction register, and three data registers:
//     - BYPASS, 1 bit
//     - IDCODE, 32 bits
//     - one USER_LEN-bit user DR with a capture/update handshake to core logic.
//   Shifting happens on the rising edge of tck. tdo, tdo_en and all update
//   side effects happen on the falling edge.
//
// Ports
//   tck            test clock
//   trst_n         asynchronous active-low reset
//   tms, tdi       sampled on tck rising edge
//   tdo, tdo_en    serial output and its enable, launched on tck falling edge
//   state          current TAP state (0 Test-Logic-Reset .. 15 Update-IR)
//   ir             active instruction
//   user_cap_data  value loaded into the user DR at Capture-DR
//   user_upd_data  user DR value latched at Update-DR (USER_OP only)
//   user_upd       one-tck-period pulse marking new user_upd_data
module jtag_tap_core #(
  parameter int                IR_LEN     = 4,
  parameter logic [31:0]       IDCODE_VAL = 32'h1000_0001,
  parameter int                USER_LEN   = 8,
  parameter logic [IR_LEN-1:0] IDCODE_OP  = 4'b0001,
  parameter logic [IR_LEN-1:0] USER_OP    = 4'b0010
) (
  input  logic                tck,
  input  logic                trst_n,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          state,
  output logic [IR_LEN-1:0]   ir,
  input  logic [USER_LEN-1:0] user_cap_data,
  output logic [USER_LEN-1:0] user_upd_data,
  output logic                user_upd
);

  typedef enum logic [3:0] {
    TLR      = 4'd0,
    RTI      = 4'd1,
    SEL_DR   = 4'd2,
    CAP_DR   = 4'd3,
    SHIFT_DR = 4'd4,
    EXIT1_DR = 4'd5,
    PAUSE_DR = 4'd6,
    EXIT2_DR = 4'd7,
    UPD_DR   = 4'd8,
    SEL_IR   = 4'd9,
    CAP_IR   = 4'd10,
    SHIFT_IR = 4'd11,
    EXIT1_IR = 4'd12,
    PAUSE_IR = 4'd13,
    EXIT2_IR = 4'd14,
    UPD_IR   = 4'd15
  } tap_state_t;

  // Capture-IR pattern: the 2'b01 required by 1149.1, zero-extended.
  localparam logic [IR_LEN-1:0] IR_CAPTURE = {{(IR_LEN-1){1'b0}}, 1'b1};

  tap_state_t          state_reg;
  logic [IR_LEN-1:0]   ir_shift_reg;
  logic [IR_LEN-1:0]   ir_reg;
  logic [31:0]         idcode_dr_reg;
  logic [USER_LEN-1:0] user_dr_reg;
  logic                bypass_dr_reg;
  logic [USER_LEN-1:0] user_upd_data_reg;
  logic                user_upd_reg;
  logic                tdo_reg;
  logic                tdo_en_reg;

  logic                sel_idcode;
  logic                sel_user;
  logic                dr_lsb;
  logic [USER_LEN-1:0] user_dr_next;

  // IDCODE wins if both opcodes were ever configured identically.
  // Every other opcode, all-ones included, falls through to BYPASS.
  assign sel_idcode = (ir_reg == IDCODE_OP);
  assign sel_user   = (ir_reg == USER_OP) && !sel_idcode;

  assign dr_lsb = sel_idcode ? idcode_dr_reg[0] :
                  sel_user   ? user_dr_reg[0]   : bypass_dr_reg;

  // A 1-bit user DR has no upper slice to shift down.
  generate
    if (USER_LEN == 1) begin : g_user_one
      assign user_dr_next = tdi;
    end else begin : g_user_wide
      assign user_dr_next = {tdi, user_dr_reg[USER_LEN-1:1]};
    end
  endgenerate

  // TAP controller state register
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_reg <= TLR;
    end else begin
      case (state_reg)
        TLR:      state_reg <= tms ? TLR      : RTI;
        RTI:      state_reg <= tms ? SEL_DR   : RTI;
        SEL_DR:   state_reg <= tms ? SEL_IR   : CAP_DR;
        CAP_DR:   state_reg <= tms ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR: state_reg <= tms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR: state_reg <= tms ? UPD_DR   : PAUSE_DR;
        PAUSE_DR: state_reg <= tms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR: state_reg <= tms ? UPD_DR   : SHIFT_DR;
        UPD_DR:   state_reg <= tms ? SEL_DR   : RTI;
        SEL_IR:   state_reg <= tms ? TLR      : CAP_IR;
        CAP_IR:   state_reg <= tms ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR: state_reg <= tms ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR: state_reg <= tms ? UPD_IR   : PAUSE_IR;
        PAUSE_IR: state_reg <= tms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR: state_reg <= tms ? UPD_IR   : SHIFT_IR;
        UPD_IR:   state_reg <= tms ? SEL_DR   : RTI;
        default:  state_reg <= TLR;
      endcase
    end
  end

  // Shift registers: capture and shift on the rising edge, keyed by the
  // pre-edge state. Only the selected DR moves; the others hold.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_shift_reg  <= '0;
      idcode_dr_reg <= '0;
      user_dr_reg   <= '0;
      bypass_dr_reg <= 1'b0;
    end else begin
      case (state_reg)
        CAP_IR:   ir_shift_reg <= IR_CAPTURE;
        SHIFT_IR: ir_shift_reg <= {tdi, ir_shift_reg[IR_LEN-1:1]};
        CAP_DR: begin
          if (sel_idcode)    idcode_dr_reg <= IDCODE_VAL;
          else if (sel_user) user_dr_reg   <= user_cap_data;
          else               bypass_dr_reg <= 1'b0;
        end
        SHIFT_DR: begin
          if (sel_idcode)    idcode_dr_reg <= {tdi, idcode_dr_reg[31:1]};
          else if (sel_user) user_dr_reg   <= user_dr_next;
          else               bypass_dr_reg <= tdi;
        end
        default: ;
      endcase
    end
  end

  // Falling-edge outputs. Test-Logic-Reset behaves like trst_n here, so a
  // five-tms=1 reset restores the IDCODE instruction without trst_n.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_reg           <= 1'b0;
      tdo_en_reg        <= 1'b0;
      ir_reg            <= IDCODE_OP;
      user_upd_reg      <= 1'b0;
      user_upd_data_reg <= '0;
    end else begin
      tdo_reg      <= 1'b0;
      tdo_en_reg   <= 1'b0;
      user_upd_reg <= 1'b0;
      case (state_reg)
        TLR: begin
          ir_reg            <= IDCODE_OP;
          user_upd_data_reg <= '0;
        end
        SHIFT_IR: begin
          tdo_reg    <= ir_shift_reg[0];
          tdo_en_reg <= 1'b1;
        end
        SHIFT_DR: begin
          tdo_reg    <= dr_lsb;
          tdo_en_reg <= 1'b1;
        end
        UPD_IR: ir_reg <= ir_shift_reg;
        UPD_DR: begin
          if (sel_user) begin
            user_upd_data_reg <= user_dr_reg;
            user_upd_reg      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state         = state_reg;
  assign ir            = ir_reg;
  assign tdo           = tdo_reg;
  assign tdo_en        = tdo_en_reg;
  assign user_upd      = user_upd_reg;
  assign user_upd_data = user_upd_data_reg;

endmodule

// File: tb/tb_jtag_tap_core.sv
// tb_jtag_tap_core
//   Directed bench for jtag_tap_core.
//   A vector table covers:
//     - IDCODE readback
//     - IR capture/load
//     - BYPASS
//   Hand-written sequences cover:
//     - the user DR handshake
//     - the Shift-IR tms reset
//     - Pause-DR resume
//     - trst_n asserted mid-shift
module tb_jtag_tap_core;

  localparam int          IR_LEN   = 4;
  localparam int          USER_LEN = 8;
  localparam logic [31:0] IDCODE   = 32'h1000_0001;

  logic                tck = 1'b0;
  logic                trst_n = 1'b0;
  logic                tms = 1'b1;
  logic                tdi = 1'b0;
  logic                tdo;
  logic                tdo_en;
  logic [3:0]          state;
  logic [IR_LEN-1:0]   ir;
  logic [USER_LEN-1:0] user_cap_data = '0;
  logic [USER_LEN-1:0] user_upd_data;
  logic                user_upd;

  jtag_tap_core #(
    .IR_LEN(IR_LEN), .IDCODE_VAL(IDCODE), .USER_LEN(USER_LEN),
    .IDCODE_OP(4'b0001), .USER_OP(4'b0010)
  ) dut (
    .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .tdo(tdo),
    .tdo_en(tdo_en), .state(state), .ir(ir), .user_cap_data(user_cap_data),
    .user_upd_data(user_upd_data), .user_upd(user_upd)
  );

  always #5 tck = ~tck;

  int upd_pulses = 0;
  always @(posedge user_upd) upd_pulses++;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic       exp_tdo;    // tdo sampled before the rising edge
    logic [3:0] exp_state;  // state after the following falling edge
    logic       exp_tdo_en;
    logic [3:0] exp_ir;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] model_ir;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at negedge+1: returns the tdo bit presented for the coming
  // rising edge, drives tms/tdi, then returns at the next negedge+1.
  task automatic step(input logic tms_v, input logic tdi_v, output logic tdo_v);
    tdo_v = tdo;
    tms = tms_v;
    tdi = tdi_v;
    @(negedge tck);
    #1;
  endtask

  task automatic add(input logic tms_v, input logic tdi_v, input logic etdo, input logic [3:0] st);
    vec_t v;
    v.tms        = tms_v;
    v.tdi        = tdi_v;
    v.exp_tdo    = etdo;
    v.exp_state  = st;
    v.exp_tdo_en = (st == 4'd4) || (st == 4'd11);
    v.exp_ir     = model_ir;
    vecs.push_back(v);
  endtask

  // IR scan from Run-Test/Idle back to Run-Test/Idle; the captured 0001
  // comes out LSB first.
  task automatic add_ir_scan(input logic [3:0] val);
    logic [3:0] cap;
    cap = 4'b0001;
    add(1, 0, 0, 4'd2);
    add(1, 0, 0, 4'd9);
    add(0, 0, 0, 4'd10);
    add(0, 0, 0, 4'd11);
    for (int i = 0; i < 4; i++)
      add(i == 3, val[i], cap[i], (i == 3) ? 4'd12 : 4'd11);
    model_ir = val;
    add(1, 0, 0, 4'd15);
    add(0, 0, 0, 4'd1);
  endtask

  task automatic scan_ir(input logic [3:0] val);
    logic b;
    step(1, 0, b); step(1, 0, b); step(0, 0, b); step(0, 0, b);
    for (int i = 0; i < 4; i++) step(i == 3, val[i], b);
    step(1, 0, b);
    step(0, 0, b);
    check("scan_ir ir", ir, val);
  endtask

  task automatic enter_shift_dr();
    logic b;
    step(1, 0, b); step(0, 0, b); step(0, 0, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        b;
    logic [31:0] idv;
    logic [4:0]  pat, exp_bp;
    logic [7:0]  uin, rd8;
    logic [31:0] rd32;
    int          base;

    idv    = IDCODE;
    pat    = 5'b01101;  // shifted 1,0,1,1,0
    exp_bp = 5'b11010;  // read  0,1,0,1,1
    uin    = 8'h3C;

    // ---- vector table ----
    model_ir = 4'b0001;
    add(0, 0, 0, 4'd1);
    add(1, 0, 0, 4'd2);
    add(0, 0, 0, 4'd3);
    add(0, 0, 0, 4'd4);
    for (int i = 0; i < 32; i++) add(i == 31, 0, idv[i], (i == 31) ? 4'd5 : 4'd4);
    add(1, 0, 0, 4'd8);
    add(0, 0, 0, 4'd1);
    add_ir_scan(4'b0010);
    add_ir_scan(4'b1111);
    add(1, 0, 0, 4'd2);
    add(0, 0, 0, 4'd3);
    add(0, 0, 0, 4'd4);
    for (int i = 0; i < 5; i++) add(i == 4, pat[i], exp_bp[i], (i == 4) ? 4'd5 : 4'd4);
    add(1, 0, 0, 4'd8);
    add(0, 0, 0, 4'd1);

    // ---- reset ----
    #21;
    check("reset state", state, 4'd0);
    check("reset ir", ir, 4'b0001);
    check("reset tdo_en", tdo_en, 1'b0);
    check("reset tdo", tdo, 1'b0);
    check("reset user_upd", user_upd, 1'b0);
    check("reset user_upd_data", user_upd_data, 8'h00);
    trst_n = 1'b1;

    foreach (vecs[k]) begin
      step(vecs[k].tms, vecs[k].tdi, b);
      check($sformatf("vec%0d tdo", k), b, vecs[k].exp_tdo);
      check($sformatf("vec%0d state", k), state, vecs[k].exp_state);
      check($sformatf("vec%0d tdo_en", k), tdo_en, vecs[k].exp_tdo_en);
      check($sformatf("vec%0d ir", k), ir, vecs[k].exp_ir);
    end

    // ---- user DR capture/update ----
    user_cap_data = 8'hA5;
    scan_ir(4'b0010);
    enter_shift_dr();
    base = upd_pulses;
    rd8 = '0;
    for (int i = 0; i < 8; i++) begin
      step(i == 7, uin[i], b);
      rd8[i] = b;
    end
    check("user tdo read", rd8, 8'hA5);
    check("user exit1 state", state, 4'd5);
    check("user upd before", user_upd, 1'b0);
    step(1, 0, b);
    check("user update state", state, 4'd8);
    check("user upd high", user_upd, 1'b1);
    check("user upd data", user_upd_data, 8'h3C);
    step(0, 0, b);
    check("user upd low", user_upd, 1'b0);
    check("user upd pulses", upd_pulses - base, 1);

    // ---- five tms=1 from Shift-IR ----
    step(1, 0, b); step(1, 0, b); step(0, 0, b); step(0, 0, b);
    check("tmsrst shift_ir", state, 4'd11);
    step(1, 1, b);
    step(1, 0, b);
    check("tmsrst update ir", ir, 4'b1000);
    step(1, 0, b); step(1, 0, b); step(1, 0, b);
    check("tmsrst state", state, 4'd0);
    check("tmsrst ir", ir, 4'b0001);

    // ---- Pause-DR resume ----
    step(0, 0, b);
    enter_shift_dr();
    rd32 = '0;
    for (int i = 0; i < 3; i++) begin
      step(i == 2, 0, b);
      rd32[i] = b;
    end
    for (int i = 0; i < 4; i++) step(0, 0, b);
    check("pause state", state, 4'd6);
    check("pause tdo_en", tdo_en, 1'b0);
    check("pause tdo", tdo, 1'b0);
    step(1, 0, b);
    check("exit2 state", state, 4'd7);
    step(0, 0, b);
    check("resume state", state, 4'd4);
    for (int i = 3; i < 32; i++) begin
      step(i == 31, 0, b);
      rd32[i] = b;
    end
    check("pause idcode read", rd32, IDCODE);
    step(1, 0, b);
    step(0, 0, b);

    // ---- trst_n mid user shift ----
    scan_ir(4'b0010);
    user_cap_data = 8'h5A;
    enter_shift_dr();
    for (int i = 0; i < 3; i++) step(0, 1, b);
    check("pre trst state", state, 4'd4);
    base = upd_pulses;
    #2 trst_n = 1'b0;
    #1;
    check("trst state", state, 4'd0);
    check("trst ir", ir, 4'b0001);
    check("trst tdo_en", tdo_en, 1'b0);
    check("trst tdo", tdo, 1'b0);
    check("trst user_upd_data", user_upd_data, 8'h00);
    @(negedge tck); #1;
    @(negedge tck); #1;
    check("trst held state", state, 4'd0);
    check("trst no upd", upd_pulses - base, 0);
    trst_n = 1'b1;
    step(0, 0, b);
    check("post trst state", state, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_tap_core.md
# jtag_tap_core

Full IEEE 1149.1-style test access port built around the 16-state TAP controller FSM. It adds a parametrised instruction register, BYPASS and IDCODE data registers, and one parametrised user data register with capture/update handshake to core logic. TDO is launched on the falling edge of TCK. The block is the JTAG front end between the board-level scan chain and on-chip debug/test logic.

## Interface
- IR_LEN, 4: instruction register width; legal range 2..8.
- IDCODE_VAL, 32'h1000_0001: IDCODE register contents; bit 0 must be 1.
- USER_LEN, 8: user data register width; legal range 1..64.
- IDCODE_OP, 4'b0001: opcode selecting IDCODE; IR_LEN bits wide.
- USER_OP, 4'b0010: opcode selecting the user DR; IR_LEN bits wide.
- tck  in  1  test clock.
- trst_n  in  1  reset, asynchronous, active-low.
- tms  in  1  test mode select, sampled on tck rising edge.
- tdi  in  1  test data in, sampled on tck rising edge.
- tdo  out  1  test data out, changes on tck falling edge.
- tdo_en  out  1  tdo output enable, changes on tck falling edge.
- state  out  4  current TAP state.
- ir  out  IR_LEN  active instruction.
- user_cap_data  in  USER_LEN  value loaded into the user DR at Capture-DR.
- user_upd_data  out  USER_LEN  user DR value latched at Update-DR.
- user_upd  out  1  one-tck pulse marking a new user_upd_data.

## Operation
- FSM state encoding: 0 Test-Logic-Reset, 1 Run-Test/Idle, 2 Select-DR, 3 Capture-DR, 4 Shift-DR, 5 Exit1-DR, 6 Pause-DR, 7 Exit2-DR, 8 Update-DR.
- Encoding continued: 9 Select-IR, 10 Capture-IR, 11 Shift-IR, 12 Exit1-IR, 13 Pause-IR, 14 Exit2-IR, 15 Update-IR.
- FSM transitions follow IEEE 1149.1 exactly. Five consecutive tms=1 edges reach state 0 from any state.
- Reset values (trst_n low, or state 0): state=0, ir=IDCODE_OP, tdo=0, tdo_en=0, user_upd=0, user_upd_data=0.
- IR shift register, IR_LEN bits:
  - In Capture-IR it loads {0..0, 2'b01}.
  - In Shift-IR it shifts right, tdi enters the MSB, and the LSB drives tdo.
- DR selection by ir:
  - IDCODE_OP selects the 32-bit IDCODE DR.
  - USER_OP selects the user DR.
  - All-ones and every other opcode select the 1-bit BYPASS DR.
- Capture-DR loads: IDCODE gets IDCODE_VAL, BYPASS gets 0, user DR gets user_cap_data.
- In Shift-DR the selected DR shifts right with tdi into the MSB. tdo is the LSB of the selected DR.
- Unselected DRs hold their contents.
- Update-IR copies the IR shift register into ir.
- Update-DR with USER_OP copies the user DR into user_upd_data and asserts user_upd. With other opcodes it has no effect.
- tdo_en is 1 only while state is Shift-IR or Shift-DR. Otherwise tdo=0.

## Timing
- Rising tck edge: state register, capture loads and shift operations, all using the pre-edge state.
- Falling tck edge:
  - tdo and tdo_en are registered from the current state and the current shift-register LSB.
  - ir, user_upd_data and user_upd update when state is Update-IR or Update-DR.
  - ir and user_upd_data change half a cycle after Update is entered.
- user_upd rises on the falling edge in Update-DR and falls on the next falling edge: one full tck period high.
- First shifted bit: after the rising edge that enters Shift-DR, the following falling edge presents bit 0 of the captured value on tdo.
- The last bit shifts on the rising edge leaving Shift-x for Exit1-x. tdo_en drops on the next falling edge.
- Pause-x and Exit2-x hold the shift register. Re-entering Shift-x resumes the shift without loss.
- State 0 forces ir=IDCODE_OP synchronously each falling edge while there, independent of trst_n.
- trst_n assertion mid-shift: all registers take reset values immediately, with no tck needed. The user DR shift contents are discarded and user_upd does not pulse.
- Deassertion of trst_n is asynchronous to tck. The first tms sample occurs on the next rising edge.

## Test plan
- Reset/IDCODE readback:
  - Pulse trst_n low: state=0, ir=4'b0001, tdo_en=0.
  - Apply tms 0,1,0,0 then 32 Shift-DR cycles: tdo yields 32'h1000_0001, LSB first.
- IR capture and load:
  - Scan Shift-IR with tdi=0010: the first 4 tdo bits read 1,0,0,0.
  - After Update-IR falling edge: ir=4'b0010.
- Bypass:
  - Load ir=4'b1111 and shift tdi pattern 1,0,1,1,0 through DR.
  - tdo returns 0,1,0,1,1: the captured 0, then the pattern delayed by one.
- User DR:
  - Set ir=USER_OP, user_cap_data=8'hA5, then shift in 8'h3C.
  - Shifted-out tdo must equal A5, LSB first.
  - After Update-DR: user_upd_data=8'h3C with a single one-period user_upd pulse.
- Pause resume: enter Shift-DR, shift 3 bits, Pause-DR for 4 cycles, Exit2 back to Shift-DR, finish. The full IDCODE is read with no dropped or repeated bit.
- Reset paths:
  - From Shift-IR, five tms=1 edges give state=0 and ir=IDCODE_OP.
  - Asserting trst_n mid user-DR shift gives state=0 at once, with no user_upd pulse.
